// File: rtl/bank_collector.sv
// bank_collector: sweeps all bank addresses and serializes each bank row onto a valid/ready stream.
// Define BANK_COLLECTOR_OREG_EN for banks with a registered output (2-cycle read latency).
module bank_collector #(
    parameter int CHANNEL_NUMBER    = 3,
    parameter int CHANNEL_BANDWIDTH = 8,
    parameter int BLOCK_DEPTH       = 12,
    parameter int BANK_ADDR_BITS    = $clog2(BLOCK_DEPTH),
    parameter int GLOBAL_ADDR_BITS  = $clog2(BLOCK_DEPTH*CHANNEL_NUMBER)
) (
    input  logic                                             I_clk_in,
    input  logic                                             I_rst_n_in,
    input  logic                                             I_start_in,
    output logic                                             O_busy_out,
    output logic                                             O_done_out,
    output logic                                             O_bank_rd_en_out,
    output logic [BANK_ADDR_BITS-1:0]                        O_bank_addr_out,
    input  logic [CHANNEL_NUMBER-1:0][CHANNEL_BANDWIDTH-1:0] I_bank_data_in,
    output logic [CHANNEL_BANDWIDTH-1:0]                     O_data_out,
    output logic [GLOBAL_ADDR_BITS-1:0]                      O_index_out,
    output logic                                             O_valid_out,
    input  logic                                             I_ready_in,
    output logic                                             O_last_out
);
    localparam int IDX_BITS = CHANNEL_NUMBER > 1 ? $clog2(CHANNEL_NUMBER) : 1;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [BANK_ADDR_BITS-1:0] addr;
    logic [IDX_BITS-1:0] idx;
    logic [CHANNEL_NUMBER-1:0][CHANNEL_BANDWIDTH-1:0] hold;
    logic wait_last, hs, idx_end, addr_end;
`ifdef BANK_COLLECTOR_OREG_EN
    logic wait_cnt;
    assign wait_last = wait_cnt;
`else
    assign wait_last = 1'b1;
`endif
    assign hs       = O_valid_out && I_ready_in;
    assign idx_end  = idx == IDX_BITS'(CHANNEL_NUMBER-1);
    assign addr_end = addr == BANK_ADDR_BITS'(BLOCK_DEPTH-1);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = I_start_in ? FETCH : IDLE;
            FETCH:   state_n = WAIT;
            WAIT:    state_n = wait_last ? SHIFT : WAIT;
            SHIFT:   state_n = hs && idx_end ? (addr_end ? DONE : FETCH) : SHIFT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign O_busy_out       = state inside {FETCH, WAIT, SHIFT};
    assign O_done_out       = state == DONE;
    assign O_bank_rd_en_out = state == FETCH;
    assign O_bank_addr_out  = addr;
    assign O_valid_out      = state == SHIFT;
    assign O_data_out       = hold[idx];
    assign O_index_out      = GLOBAL_ADDR_BITS'(addr) * GLOBAL_ADDR_BITS'(CHANNEL_NUMBER) + GLOBAL_ADDR_BITS'(idx);
    assign O_last_out       = O_valid_out && idx_end && addr_end;
    // idx parks at the last channel after its handshake; the next WAIT rewinds it
    always_ff @(posedge I_clk_in or negedge I_rst_n_in) begin
        if (!I_rst_n_in) begin
            state <= IDLE;
            addr  <= '0;
            idx   <= '0;
            hold  <= '0;
`ifdef BANK_COLLECTOR_OREG_EN
            wait_cnt <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (state == IDLE && I_start_in) addr <= '0;
            if (state == WAIT && wait_last) begin
                hold <= I_bank_data_in;
                idx  <= '0;
            end
            if (hs) begin
                if (!idx_end) idx <= idx + IDX_BITS'(1);
                else if (!addr_end) addr <= addr + BANK_ADDR_BITS'(1);
            end
`ifdef BANK_COLLECTOR_OREG_EN
            if (state == WAIT) wait_cnt <= ~wait_cnt;
`endif
        end
    end
endmodule

// File: tb/tb_bank_collector.sv
// tb_bank_collector: scoreboard bench for bank_collector with a tagged bank model.
// Build with BANK_COLLECTOR_OREG_EN to use the 2-cycle bank model and 6-cycle address period.
module tb_bank_collector;
    localparam int N = 3, BW = 8, D = 12, AB = $clog2(D), GB = $clog2(D*N);
`ifdef BANK_COLLECTOR_OREG_EN
    localparam int PER = N + 3;
`else
    localparam int PER = N + 2;
`endif
    typedef struct packed {logic [BW-1:0] data; logic [GB-1:0] index; logic last;} word_t;
    logic clk = 0, rst_n = 0, start = 0, ready = 0;
    logic busy, done, rd_en, valid, last;
    logic [AB-1:0] addr;
    logic [N-1:0][BW-1:0] bank_data, stage1;
    logic [BW-1:0] data;
    logic [GB-1:0] index;
    word_t q[$];
    word_t prev_w, pop_w, stall_w;
    int compared = 0, mismatched = 0, cyc = 0, done_cnt = 0, last_rd = -1;
    logic per_chk = 0, pend_done = 0, prev_stall = 0;

    always #5 clk = ~clk;

    bank_collector dut (
        .I_clk_in(clk), .I_rst_n_in(rst_n), .I_start_in(start), .O_busy_out(busy),
        .O_done_out(done), .O_bank_rd_en_out(rd_en), .O_bank_addr_out(addr),
        .I_bank_data_in(bank_data), .O_data_out(data), .O_index_out(index),
        .O_valid_out(valid), .I_ready_in(ready), .O_last_out(last)
    );

    // bank b at address a returns {b[2:0], a[4:0]}; unstrobed cycles return filler
    always @(posedge clk)
        for (int b = 0; b < N; b++) stage1[b] <= rd_en ? {3'(b), 5'(addr)} : 8'hEE;
`ifdef BANK_COLLECTOR_OREG_EN
    always @(posedge clk) bank_data <= stage1;
`else
    assign bank_data = stage1;
`endif

    function automatic word_t exp_word(int g);
        word_t w;
        w.data  = {3'(g % N), 5'(g / N)};
        w.index = GB'(g);
        w.last  = (g == N*D-1);
        return w;
    endfunction

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            pend_done  = 0;
            prev_stall = 0;
        end else begin
            if (pend_done || done) chk("done_pulse", 32'(done), 32'(pend_done));
            if (done) done_cnt++;
            pend_done = 0;
            if (prev_stall) begin
                chk("stall_valid", 32'(valid), 1);
                chk("stall_word", 32'({data, index, last}), 32'(prev_w));
            end
            if (rd_en) begin
                if (per_chk && last_rd >= 0) chk("addr_period", cyc - last_rd, PER);
                last_rd = cyc;
            end
            if (!per_chk) last_rd = -1;
            if (valid && ready) begin
                if (q.size() == 0) chk("extra_word", q.size(), 1);
                else begin
                    pop_w = q.pop_front();
                    chk("word", 32'({data, index, last}), 32'(pop_w));
                end
                pend_done = last;
            end
            prev_stall = valid && !ready;
            prev_w = {data, index, last};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1;
        for (int g = 0; g < N*D; g++) q.push_back(exp_word(g));
        tick;
        start = 0;
    endtask

    task automatic run(input bit rnd, input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick;
            n++;
        end
        chk("sweep_done", done_cnt - d0, 1);
        chk("queue_empty", q.size(), 0);
    endtask

    task automatic reset_chk;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_index", 32'(index), 0);
        chk("rst_last", 32'(last), 0);
    endtask

    initial begin
        int n;
        tick;
        tick;
        reset_chk;
        rst_n = 1;
        tick;
        per_chk = 1;
        do_start;
        run(0, 500);
        per_chk = 0;
        chk("done_count", done_cnt, 1);
        do_start;
        run(1, 2000);
        ready = 1;
        do_start;
        for (int i = 0; i < 3; i++) begin
            start = 1;
            tick;
        end
        start = 0;
        run(0, 500);
        do_start;
        n = 0;
        while (!done && n < 500) begin
            tick;
            n++;
        end
        chk("reach_done", 32'(done), 1);
        start = 1;
        tick;
        start = 0;
        chk("start_at_done_busy", 32'(busy), 0);
        tick;
        chk("start_at_done_rd", 32'(rd_en), 0);
        chk("done_count_all", done_cnt, 4);
        do_start;
        n = 0;
        while (!(valid && index == GB'(17)) && n < 500) begin
            tick;
            n++;
        end
        chk("reach_g17", 32'(index), 17);
        rst_n = 0;
        #1;
        reset_chk;
        tick;
        rst_n = 1;
        tick;
        do_start;
        run(0, 500);
        do_start;
        n = 0;
        while (!(valid && index == GB'(2)) && n < 500) begin
            tick;
            n++;
        end
        ready = 0;
        stall_w = exp_word(2);
        for (int i = 0; i < 50; i++) begin
            tick;
            chk("stall50_valid", 32'(valid), 1);
            chk("stall50_data", 32'(data), 32'(stall_w.data));
        end
        run(0, 500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
